// File: rtl/divisor_sequencial_pkg.sv
// Shared definitions for the sequential divider: state codes and default width.
package divisor_sequencial_pkg;

    localparam int DEF_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

endpackage

// File: rtl/divisor_sequencial_if.sv
// Request/result bundle between the control unit (master) and the divider (slave).
interface divisor_sequencial_if
    import divisor_sequencial_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic             start;
    logic             signed_op;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             busy;
    logic             done;
    logic             div_zero;

    modport master (
        output start, signed_op, dividend, divisor,
        input  quotient, remainder, busy, done, div_zero
    );

    modport slave (
        input  start, signed_op, dividend, divisor,
        output quotient, remainder, busy, done, div_zero
    );
endinterface

// File: rtl/divisor_sequencial_subtrator_parcial.sv
// Combinational trial subtractor: diff = a - b, borrow set when a < b.
module subtrator_parcial #(
    parameter int W = 17
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] diff,
    output logic         borrow
);

    // Extend by one bit so the carry-out of the subtraction is the borrow.
    assign {borrow, diff} = {1'b0, a} - {1'b0, b};

endmodule

// File: rtl/divisor_sequencial.sv
// Multi-cycle restoring divider (DIV/DIVU): quotient -> LO, remainder -> HI.
//
//  state | meaning
//  IDLE  | waiting for start
//  CALC  | one shift/trial-subtract step per cycle, WIDTH cycles
//  FIX   | sign correction and divide-by-zero override of the raw result
//  DONE  | results valid for one cycle, new start accepted here
module divisor_sequencial
    import divisor_sequencial_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input logic                 clk,
    input logic                 rst,
    divisor_sequencial_if.slave bus
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    div_state_t       state;
    div_state_t       nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] d_q;
    logic [WIDTH-1:0] a_orig;
    logic             sgn;
    logic             sq;
    logic             sr;
    logic             dz;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] rem_q;
    logic             dz_out;

    logic             busy_w;
    logic             accept;
    logic [WIDTH:0]   trial_a;
    logic [WIDTH:0]   trial_b;
    logic [WIDTH:0]   trial_d;
    logic             trial_borrow;
    logic [WIDTH-1:0] fix_quo;
    logic [WIDTH-1:0] fix_rem;

    assign busy_w = (state == CALC) || (state == FIX);
    assign accept = bus.start && !busy_w;

    // The bit shifted out of R is kept as the MSB of the trial operand, so
    // divisors above 2^(WIDTH-1) in unsigned mode still compare correctly.
    assign trial_a = {r_q, q_q[WIDTH-1]};
    assign trial_b = {1'b0, d_q};

    subtrator_parcial #(.W(WIDTH + 1)) u_sub (
        .a      (trial_a),
        .b      (trial_b),
        .diff   (trial_d),
        .borrow (trial_borrow)
    );

    // Final result: divide-by-zero override, otherwise sign-corrected magnitudes.
    always_comb begin
        fix_quo = q_q;
        fix_rem = r_q;
        if (dz) begin
            fix_quo = '1;
            fix_rem = a_orig;
        end else begin
            if (sgn && sq) fix_quo = -q_q;
            if (sgn && sr) fix_rem = -r_q;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nxt;
    end

    // Next-state logic.
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (bus.start) nxt = CALC;
            CALC:    if (cnt == '0) nxt = FIX;
            FIX:     nxt = DONE;
            DONE:    nxt = bus.start ? CALC : IDLE;
            default: nxt = IDLE;
        endcase
    end

    // Operand latch, iteration datapath and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            r_q    <= '0;
            q_q    <= '0;
            d_q    <= '0;
            a_orig <= '0;
            sgn    <= 1'b0;
            sq     <= 1'b0;
            sr     <= 1'b0;
            dz     <= 1'b0;
            quo_q  <= '0;
            rem_q  <= '0;
            dz_out <= 1'b0;
        end else begin
            if (accept) begin
                cnt    <= CW'(WIDTH - 1);
                r_q    <= '0;
                q_q    <= (bus.signed_op && bus.dividend[WIDTH-1]) ? -bus.dividend : bus.dividend;
                d_q    <= (bus.signed_op && bus.divisor[WIDTH-1])  ? -bus.divisor  : bus.divisor;
                a_orig <= bus.dividend;
                sgn    <= bus.signed_op;
                sq     <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
                sr     <= bus.dividend[WIDTH-1];
                dz     <= (bus.divisor == '0);
            end else if (state == CALC) begin
                cnt <= cnt - CW'(1);
                if (!trial_borrow) begin
                    r_q <= trial_d[WIDTH-1:0];
                    q_q <= {q_q[WIDTH-2:0], 1'b1};
                end else begin
                    r_q <= trial_a[WIDTH-1:0];
                    q_q <= {q_q[WIDTH-2:0], 1'b0};
                end
            end
            if (state == FIX) begin
                quo_q  <= fix_quo;
                rem_q  <= fix_rem;
                dz_out <= dz;
            end
        end
    end

    assign bus.quotient  = quo_q;
    assign bus.remainder = rem_q;
    assign bus.busy      = busy_w;
    assign bus.done      = (state == DONE);
    assign bus.div_zero  = dz_out;

endmodule

// File: tb/tb_divisor_sequencial.sv
// Directed bench for the 16-bit sequential divider.
module tb_divisor_sequencial;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    divisor_sequencial_if #(.WIDTH(16)) bus ();

    divisor_sequencial #(.WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick;
        tick;
        rst = 1'b0;
        n_cmp++; if (bus.busy !== 1'b0)      begin n_bad++; $display("FAIL reset busy: got %b want 0", bus.busy); end
        n_cmp++; if (bus.done !== 1'b0)      begin n_bad++; $display("FAIL reset done: got %b want 0", bus.done); end
        n_cmp++; if (bus.quotient !== 16'h0) begin n_bad++; $display("FAIL reset quotient: got %h want 0000", bus.quotient); end
        n_cmp++; if (bus.remainder !== 16'h0) begin n_bad++; $display("FAIL reset remainder: got %h want 0000", bus.remainder); end
        n_cmp++; if (bus.div_zero !== 1'b0)  begin n_bad++; $display("FAIL reset div_zero: got %b want 0", bus.div_zero); end
    endtask

    task automatic test_divide(input string nm, input logic sop, input logic [15:0] a, input logic [15:0] b,
                               input logic [15:0] eq, input logic [15:0] er, input logic ez);
        int cyc;
        bus.signed_op = sop;
        bus.dividend  = a;
        bus.divisor   = b;
        bus.start     = 1'b1;
        tick;
        bus.start     = 1'b0;
        bus.dividend  = ~a;
        bus.divisor   = b ^ 16'h5a5a;
        bus.signed_op = ~sop;
        cyc = 1;
        n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL %s busy_c1: got %b want 1", nm, bus.busy); end
        while (bus.done !== 1'b1 && cyc < 40) begin
            tick;
            cyc++;
        end
        n_cmp++; if (cyc !== 18)            begin n_bad++; $display("FAIL %s latency: got %0d want 18", nm, cyc); end
        n_cmp++; if (bus.busy !== 1'b0)     begin n_bad++; $display("FAIL %s busy_done: got %b want 0", nm, bus.busy); end
        n_cmp++; if (bus.quotient !== eq)   begin n_bad++; $display("FAIL %s quotient: got %h want %h", nm, bus.quotient, eq); end
        n_cmp++; if (bus.remainder !== er)  begin n_bad++; $display("FAIL %s remainder: got %h want %h", nm, bus.remainder, er); end
        n_cmp++; if (bus.div_zero !== ez)   begin n_bad++; $display("FAIL %s div_zero: got %b want %b", nm, bus.div_zero, ez); end
        tick;
        n_cmp++; if (bus.done !== 1'b0)     begin n_bad++; $display("FAIL %s done_pulse: got %b want 0", nm, bus.done); end
        n_cmp++; if (bus.quotient !== eq)   begin n_bad++; $display("FAIL %s quotient_held: got %h want %h", nm, bus.quotient, eq); end
    endtask

    task automatic test_ignore_start;
        int cyc;
        bus.signed_op = 1'b0;
        bus.dividend  = 16'd100;
        bus.divisor   = 16'd7;
        bus.start     = 1'b1;
        tick;
        bus.start = 1'b0;
        cyc = 1;
        repeat (4) begin tick; cyc++; end
        bus.dividend  = 16'h1234;
        bus.divisor   = 16'd3;
        bus.signed_op = 1'b1;
        bus.start     = 1'b1;
        tick;
        cyc++;
        bus.start = 1'b0;
        while (bus.done !== 1'b1 && cyc < 40) begin
            tick;
            cyc++;
        end
        n_cmp++; if (cyc !== 18)              begin n_bad++; $display("FAIL ignore latency: got %0d want 18", cyc); end
        n_cmp++; if (bus.quotient !== 16'd14) begin n_bad++; $display("FAIL ignore quotient: got %h want 000e", bus.quotient); end
        n_cmp++; if (bus.remainder !== 16'd2) begin n_bad++; $display("FAIL ignore remainder: got %h want 0002", bus.remainder); end
        repeat (25) begin
            tick;
            n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL ignore extra_done: got %b want 0", bus.done); end
        end
    endtask

    task automatic test_back_to_back;
        int cyc;
        bus.signed_op = 1'b0;
        bus.dividend  = 16'd1000;
        bus.divisor   = 16'd9;
        bus.start     = 1'b1;
        tick;
        bus.start = 1'b0;
        cyc = 1;
        while (bus.done !== 1'b1 && cyc < 40) begin
            tick;
            cyc++;
        end
        n_cmp++; if (cyc !== 18)               begin n_bad++; $display("FAIL b2b first_latency: got %0d want 18", cyc); end
        n_cmp++; if (bus.quotient !== 16'd111) begin n_bad++; $display("FAIL b2b first_quotient: got %h want 006f", bus.quotient); end
        bus.signed_op = 1'b1;
        bus.dividend  = 16'hFFF9;
        bus.divisor   = 16'd2;
        bus.start     = 1'b1;
        tick;
        cyc++;
        bus.start = 1'b0;
        n_cmp++; if (bus.busy !== 1'b1)        begin n_bad++; $display("FAIL b2b accept_busy: got %b want 1", bus.busy); end
        n_cmp++; if (bus.quotient !== 16'd111) begin n_bad++; $display("FAIL b2b held_quotient: got %h want 006f", bus.quotient); end
        n_cmp++; if (bus.remainder !== 16'd1)  begin n_bad++; $display("FAIL b2b held_remainder: got %h want 0001", bus.remainder); end
        while (bus.done !== 1'b1 && cyc < 60) begin
            tick;
            cyc++;
        end
        n_cmp++; if (cyc !== 36)                 begin n_bad++; $display("FAIL b2b second_latency: got %0d want 36", cyc); end
        n_cmp++; if (bus.quotient !== 16'hFFFD)  begin n_bad++; $display("FAIL b2b second_quotient: got %h want fffd", bus.quotient); end
        n_cmp++; if (bus.remainder !== 16'hFFFF) begin n_bad++; $display("FAIL b2b second_remainder: got %h want ffff", bus.remainder); end
        tick;
    endtask

    task automatic test_reset_mid;
        bus.signed_op = 1'b0;
        bus.dividend  = 16'd500;
        bus.divisor   = 16'd3;
        bus.start     = 1'b1;
        tick;
        bus.start = 1'b0;
        repeat (7) tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        n_cmp++; if (bus.busy !== 1'b0)       begin n_bad++; $display("FAIL rstmid busy: got %b want 0", bus.busy); end
        n_cmp++; if (bus.done !== 1'b0)       begin n_bad++; $display("FAIL rstmid done: got %b want 0", bus.done); end
        n_cmp++; if (bus.quotient !== 16'h0)  begin n_bad++; $display("FAIL rstmid quotient: got %h want 0000", bus.quotient); end
        n_cmp++; if (bus.remainder !== 16'h0) begin n_bad++; $display("FAIL rstmid remainder: got %h want 0000", bus.remainder); end
        repeat (25) begin
            tick;
            n_cmp++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
                n_bad++; $display("FAIL rstmid late_activity: got done=%b busy=%b want 0 0", bus.done, bus.busy);
            end
        end
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.signed_op = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        test_reset;
        test_divide("u100_7",     1'b0, 16'd100,  16'd7,     16'd14,   16'd2,    1'b0);
        test_divide("s_m100_7",   1'b1, 16'hFF9C, 16'h0007,  16'hFFF2, 16'hFFFE, 1'b0);
        test_divide("u_ffff_1",   1'b0, 16'hFFFF, 16'h0001,  16'hFFFF, 16'h0000, 1'b0);
        test_divide("u1234_0",    1'b0, 16'd1234, 16'h0000,  16'hFFFF, 16'h04D2, 1'b1);
        test_divide("s_ovf",      1'b1, 16'h8000, 16'hFFFF,  16'h8000, 16'h0000, 1'b0);
        test_divide("u_bigdiv",   1'b0, 16'hFFFF, 16'h8001,  16'h0001, 16'h7FFE, 1'b0);
        test_divide("u_8000_ffff",1'b0, 16'h8000, 16'hFFFF,  16'h0000, 16'h8000, 1'b0);
        test_divide("s_7_m2",     1'b1, 16'h0007, 16'hFFFE,  16'hFFFD, 16'h0001, 1'b0);
        test_divide("s_m5_0",     1'b1, 16'hFFFB, 16'h0000,  16'hFFFF, 16'hFFFB, 1'b1);
        test_ignore_start;
        test_back_to_back;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
